// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped instruction cache responder with line refill and uncached fetch
module icache_responder #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_req,
    input  logic        icache_iscache,
    input  logic [3:0]  icache_offset,
    input  logic [7:0]  icache_index,
    input  logic [19:0] icache_tag,
    output logic        icache_addr_ok,
    output logic        icache_data_ok,
    output logic [31:0] icache_rdata,
    input  logic        inv_valid,
    input  logic [7:0]  inv_index,
    output logic        inv_ok,
    output logic        rd_req,
    output logic        rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] MISS   = 3'd2;
    localparam logic [2:0] REFILL = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [1:0]  off_q;
    logic [7:0]  idx_q;
    logic [19:0] tag_q;
    logic        isc_q;
    logic [1:0]  cnt_q;
    logic [31:0] rdata_q;
    logic [SETS-1:0] valid_q;

    logic [19:0] tag_arr  [SETS];
    logic [31:0] data_arr [SETS][LINE_WORDS];
    logic [31:0] buf_q    [LINE_WORDS];

    logic hit;
    logic lookup_hit;
    logic refill_done;
    logic unused_offset_lsbs;

    assign unused_offset_lsbs = ^icache_offset[1:0];

    assign hit         = isc_q & valid_q[idx_q] & (tag_arr[idx_q] == tag_q);
    assign lookup_hit  = (state_q == LOOKUP) & hit;
    assign refill_done = (state_q == REFILL) & ret_valid & ret_last;

    // Invalidate wins over a fetch in the same cycle; both are gated off while reset is high.
    assign inv_ok         = ~reset & (state_q == IDLE) & inv_valid;
    assign icache_addr_ok = ~reset & icache_req & ~inv_valid
                          & ((state_q == IDLE) | lookup_hit);
    assign icache_data_ok = ~reset & (lookup_hit | (state_q == RESP));

    assign rd_req  = (state_q == MISS);
    assign rd_type = (state_q == MISS) & isc_q;
    assign rd_addr = (state_q != MISS) ? 32'd0 :
                     isc_q ? {tag_q, idx_q, 4'b0000} : {tag_q, idx_q, off_q, 2'b00};

    always_comb begin
        icache_rdata = rdata_q;
        if (lookup_hit) begin
            icache_rdata = data_arr[idx_q][off_q];
        end else if (state_q == RESP) begin
            icache_rdata = isc_q ? buf_q[off_q] : buf_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (icache_addr_ok) state_d = LOOKUP;
            LOOKUP:  if (hit) state_d = icache_addr_ok ? LOOKUP : IDLE;
                     else     state_d = MISS;
            MISS:    if (rd_rdy) state_d = REFILL;
            REFILL:  if (ret_valid && ret_last) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            off_q   <= 2'd0;
            idx_q   <= 8'd0;
            tag_q   <= 20'd0;
            isc_q   <= 1'b0;
            cnt_q   <= 2'd0;
            rdata_q <= 32'd0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (icache_addr_ok) begin
                off_q <= icache_offset[3:2];
                idx_q <= icache_index;
                tag_q <= icache_tag;
                isc_q <= icache_iscache;
            end
            if (icache_data_ok) rdata_q <= icache_rdata;
            if (state_q == REFILL && ret_valid) begin
                cnt_q <= ret_last ? 2'd0 : cnt_q + 2'd1;
            end
            if (inv_ok) begin
                valid_q[inv_index] <= 1'b0;
            end else if (refill_done && isc_q) begin
                valid_q[idx_q] <= 1'b1;
            end
        end
    end

    // The last beat goes straight into the array alongside the three buffered beats.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && ret_valid) begin
            buf_q[cnt_q] <= ret_data;
        end
        if (refill_done && isc_q) begin
            tag_arr[idx_q] <= tag_q;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_arr[idx_q][w] <= (2'(w) == cnt_q) ? ret_data : buf_q[w];
            end
        end
    end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 SHALL have the parameter LINE_WORDS, default 4, meaning 32-bit words per cache line; only the value 4 is supported.
REQ-002 SHALL have the parameter SETS, default 256, meaning the number of direct-mapped sets; only the value 256 is supported.
REQ-003 SHALL provide port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, width 1: asynchronous, active-high reset.
REQ-005 SHALL provide port icache_req, input, width 1: fetch request valid.
REQ-006 SHALL provide port icache_iscache, input, width 1: 1 = cacheable, 0 = uncached.
REQ-007 SHALL provide port icache_offset, input, width 4: byte offset within the line; bits [1:0] are ignored.
REQ-008 SHALL provide port icache_index, input, width 8: set index.
REQ-009 SHALL provide port icache_tag, input, width 20: physical tag.
REQ-010 SHALL provide port icache_addr_ok, output, width 1: request accepted this cycle.
REQ-011 SHALL provide port icache_data_ok, output, width 1: instruction returned this cycle.
REQ-012 SHALL provide port icache_rdata, output, width 32: returned instruction.
REQ-013 SHALL provide port inv_valid, input, width 1: index-invalidate request.
REQ-014 SHALL provide port inv_index, input, width 8: set to invalidate.
REQ-015 SHALL provide port inv_ok, output, width 1: invalidate performed this cycle.
REQ-016 SHALL provide port rd_req, output, width 1: memory read request.
REQ-017 SHALL provide port rd_type, output, width 1: 0 = single word, 1 = full line.
REQ-018 SHALL provide port rd_addr, output, width 32: memory read address.
REQ-019 SHALL provide port rd_rdy, input, width 1: memory accepted rd_req.
REQ-020 SHALL provide port ret_valid, input, width 1: return word valid.
REQ-021 SHALL provide port ret_last, input, width 1: final return word.
REQ-022 SHALL provide port ret_data, input, width 32: return word.

Function
REQ-023 SHALL implement a direct-mapped cache of 256 sets, each set holding a valid bit, a 20-bit tag and 4 data words.
REQ-024 SHALL implement the states IDLE, LOOKUP, MISS, REFILL and RESP.
REQ-025 SHALL assert icache_addr_ok = icache_req & !inv_valid & (state==IDLE | (state==LOOKUP & hit)); on acceptance it SHALL latch offset, index, tag and iscache and enter LOOKUP.
REQ-026 SHALL compute hit in LOOKUP as latched iscache & valid[index] & (tag[index]==latched tag).
REQ-027 On a hit in LOOKUP, SHALL assert icache_data_ok with icache_rdata = data[index][offset[3:2]], giving a latency of 1 cycle after acceptance.
REQ-028 On a hit in LOOKUP, SHALL go to LOOKUP if a new request is accepted that cycle and to IDLE otherwise, sustaining 1 hit per cycle back-to-back.
REQ-029 On a miss or uncached access in LOOKUP, SHALL assert no data_ok and enter MISS.
REQ-030 In MISS, SHALL hold rd_req=1 with rd_type, rd_addr stable until rd_rdy, then enter REFILL.
REQ-031 For a cached miss in MISS, SHALL drive rd_type=1 and rd_addr={tag,index,4'b0}.
REQ-032 For an uncached access in MISS, SHALL drive rd_type=0 and rd_addr={tag,index,offset[3:2],2'b00}.
REQ-033 In REFILL, SHALL keep a 2-bit word counter from 0, capture each word on ret_valid and increment the counter, wrapping 3 to 0.
REQ-034 On the ret_valid & ret_last cycle, SHALL enter RESP; for a cached refill the full line, the tag and valid=1 SHALL be written at that edge.
REQ-035 An uncached return SHALL never modify the tag, data or valid arrays.
REQ-036 In RESP, SHALL assert icache_data_ok for exactly 1 cycle with the requested word (the word at the latched offset, or the single uncached word), then enter IDLE.
REQ-037 SHALL keep icache_addr_ok=0 in MISS, REFILL and RESP.
REQ-038 In IDLE, SHALL act on inv_valid: clear valid[inv_index] at the next edge and assert inv_ok in the same cycle.
REQ-039 inv_valid SHALL take priority over icache_req in the same cycle, so the request is not accepted.
REQ-040 SHALL assert inv_ok=0 outside IDLE; the requester holds inv_valid.
REQ-041 An invalidate arriving while a refill is pending SHALL be performed after the refill and RESP complete.
REQ-042 SHALL ignore ret_valid outside REFILL.
REQ-043 SHALL hold icache_rdata at its last value whenever data_ok=0.

Reset
REQ-044 Reset SHALL asynchronously force state=IDLE, all 256 valid bits=0 and the word counter=0.
REQ-045 Reset SHALL asynchronously force icache_addr_ok, icache_data_ok, inv_ok and rd_req to 0, and icache_rdata, rd_addr and rd_type to 0.
REQ-046 Tag and data arrays SHALL need no reset.
REQ-047 Reset asserted mid-refill SHALL abandon the refill with no partial line marked valid.

Verification
REQ-048 The bench SHALL cover a cold miss: req iscache=1, tag=0x1FC00, index=0, offset=4 -> rd_req with rd_type=1, rd_addr=0x1FC00000; return 4 words A0..A3 with ret_last on A3 -> data_ok with rdata=A1, 1 cycle after the last word.
REQ-049 The bench SHALL cover back-to-back hits: after REQ-048, requests on 4 consecutive cycles at offsets 0, 4, 8, 12 -> addr_ok on every cycle and data_ok on the following cycles returning A0..A3 in order, with no rd_req.
REQ-050 The bench SHALL cover an uncached access: iscache=0, tag=0x1FC00, index=0x37, offset=0xC -> rd_type=0, rd_addr=0x1FC0037C; 1 returned word W with ret_last -> data_ok with rdata=W; a following cached access to index 0x37 misses.
REQ-051 The bench SHALL cover invalidate-versus-request: inv_valid with inv_index=0 together with req to index 0 in IDLE -> inv_ok=1 and addr_ok=0; the retried request misses and reissues rd_addr=0x1FC00000.
REQ-052 The bench SHALL cover a stalled handshake: rd_rdy held low for 5 cycles -> rd_req and rd_addr stable for all 5 cycles and addr_ok=0 throughout.
REQ-053 The bench SHALL cover reset mid-refill: reset after 2 of 4 words -> all outputs 0 immediately; a subsequent request to the same line misses.
